// File: rtl/rom_stream_dumper.sv
// Streams ROM words 0..last_address to a host, one word per host sck pulse; ack follows the ROM read by one cycle.
// Stalls on sck (host), rom_busy and rom_initialized; dump low aborts the session and drops any pending read.
module rom_stream_dumper #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dump,
  input  logic [ADDRESS_WIDTH-1:0] last_address,
  input  logic                     sck,
  output logic [DATA_WIDTH-1:0]    output_data,
  output logic                     ack,
  output logic                     done,
  input  logic                     rom_busy,
  input  logic                     rom_initialized,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     rom_request,
  output logic [ADDRESS_WIDTH-1:0] rom_address
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WAIT_SCK     = 3'd1;
  localparam logic [2:0] REQUEST      = 3'd2;
  localparam logic [2:0] READING      = 3'd3;
  localparam logic [2:0] WAIT_SCK_LOW = 3'd4;
  localparam logic [2:0] DONE         = 3'd5;

  logic [2:0]               state;
  logic                     dump_prev;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-1:0] last_addr_q;

  assign rom_address = addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      dump_prev   <= 1'b0;
      addr        <= '0;
      last_addr_q <= '0;
      output_data <= '0;
      ack         <= 1'b0;
      done        <= 1'b0;
      rom_request <= 1'b0;
    end else begin
      dump_prev <= dump;
      ack       <= 1'b0;
      if (dump && !dump_prev) begin
        state       <= WAIT_SCK;
        addr        <= '0;
        last_addr_q <= last_address;
        rom_request <= 1'b0;
        done        <= 1'b0;
      end else if (!dump) begin
        // Abort: the counter is left untouched so the host can see where it stopped.
        state       <= IDLE;
        rom_request <= 1'b0;
        done        <= 1'b0;
      end else begin
        case (state)
          WAIT_SCK: begin
            if (sck && !rom_busy && rom_initialized) begin
              rom_request <= 1'b1;
              state       <= REQUEST;
            end
          end
          REQUEST: begin
            if (rom_busy) begin
              rom_request <= 1'b0;
              state       <= READING;
            end
          end
          READING: begin
            if (!rom_busy) begin
              output_data <= rom_data;
              ack         <= 1'b1;
              state       <= WAIT_SCK_LOW;
            end
          end
          WAIT_SCK_LOW: begin
            // Comparing before incrementing keeps an all-ones last_address from wrapping to 0.
            if (!sck) begin
              if (addr == last_addr_q) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                addr  <= addr + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                state <= WAIT_SCK;
              end
            end
          end
          DONE: begin
            done <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/rom_stream_dumper.md
ROM_STREAM_DUMPER -- requirements
Module: rom_stream_dumper

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of ROM words and streamed data.
REQ-002 Parameter ADDRESS_WIDTH, default 16, width of ROM address and word counter.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-005 dump  input  1  host level; high = dump session active, rising edge starts a new session at address 0.
REQ-006 last_address  input  ADDRESS_WIDTH  final address to read; sampled only on the session start cycle.
REQ-007 sck  input  1  host strobe; high = host requests next word, must return low before the following word.
REQ-008 output_data  output  DATA_WIDTH  last word read from ROM, stable from ack until the next read completes.
REQ-009 ack  output  1  one-cycle pulse: output_data holds a new valid word.
REQ-010 done  output  1  high once the word at last_address has been delivered and sck has returned low.
REQ-011 rom_busy  input  1  ROM controller busy with an access.
REQ-012 rom_initialized  input  1  ROM controller ready for use.
REQ-013 rom_data  input  DATA_WIDTH  read data from ROM, valid on the cycle rom_busy falls after a read.
REQ-014 rom_request  output  1  read request to ROM; held until rom_busy is seen high.
REQ-015 rom_address  output  ADDRESS_WIDTH  current read address, equal to the internal word counter.

Function
REQ-016 States IDLE, WAIT_SCK, REQUEST, READING, WAIT_SCK_LOW, DONE; one state active per cycle.
REQ-017 Session start (dump high and dump low on the previous cycle): address := 0, last_address captured, next state WAIT_SCK, from any state.
REQ-018 WAIT_SCK: when sck && !rom_busy && rom_initialized, assert rom_request the next cycle and go to REQUEST; otherwise hold.
REQ-019 rom_request SHALL never rise on a cycle following one where rom_busy was high or rom_initialized was low.
REQ-020 REQUEST: while rom_busy low, hold rom_request high; on rom_busy high, deassert rom_request the next cycle and go to READING.
REQ-021 READING: on rom_busy low, register rom_data into output_data, pulse ack for exactly one cycle, go to WAIT_SCK_LOW.
REQ-022 Latency: ack SHALL appear exactly one cycle after the cycle in which rom_busy is first low in READING.
REQ-023 WAIT_SCK_LOW: on sck low, if address == captured last_address go to DONE, else address := address + 1 and go to WAIT_SCK.
REQ-024 A sck held high across a word SHALL NOT trigger a second read; exactly one word per sck high pulse.
REQ-025 DONE: done high, no further rom_request; remain until dump low.
REQ-026 last_address all-ones: final word at address 2^ADDRESS_WIDTH-1 read, counter SHALL NOT wrap to 0, done asserted.
REQ-027 last_address 0: exactly one word (address 0) delivered, then done.
REQ-028 dump low in any state: next state IDLE, rom_request low next cycle, done low, no ack generated for an aborted read, address held.
REQ-029 dump low then high while ROM still busy from an aborted read: new session waits in WAIT_SCK until rom_busy low.
REQ-030 rom_request and ack SHALL never be high in the same cycle; ack only in transition READING->WAIT_SCK_LOW.
REQ-031 rom_request SHALL be low whenever rom_initialized is low and no request was pending.

Reset
REQ-032 reset_n low at a posedge: state IDLE, rom_request 0, ack 0, done 0, output_data 0, rom_address 0, captured last_address 0, previous-dump flag 0.
REQ-033 Reset mid-read SHALL drop rom_request next cycle and discard the pending word; dump high after reset release counts as a session start.

Verification
REQ-034 last_address=3, ROM returns 0xA000+addr, host pulses sck 4 times -> 4 acks with output_data 0xA000..0xA003, rom_address 0..3, done high after 4th sck low.
REQ-035 rom_initialized low for 20 cycles with dump and sck high -> rom_request stays 0; rises within 2 cycles after rom_initialized high.
REQ-036 sck held high for 30 cycles after first ack, ROM busy 5 cycles per read -> exactly one ack, no second rom_request until sck low then high.
REQ-037 dump dropped while in READING at address 2 -> no ack, rom_request 0, done 0; dump re-raised -> first read at rom_address 0.
REQ-038 ADDRESS_WIDTH=4, last_address=0xF -> 16 words read, rom_address ends at 0xF, done high, no request to 0x0 afterwards.
REQ-039 reset_n low for one cycle during REQUEST -> all outputs at reset values next cycle; no ack until a new session completes a read.
